// File: rtl/status_readback_pkg.sv
// status_readback_pkg: register map, STATUS/CTRL bit positions and FSM encoding for the status responder.
package status_readback_pkg;
  localparam logic [3:0] ADDR_STATUS    = 4'h0;
  localparam logic [3:0] ADDR_MMCM_LOSS = 4'h1;
  localparam logic [3:0] ADDR_CORE_LOSS = 4'h2;
  localparam logic [3:0] ADDR_TRIG_LOSS = 4'h3;
  localparam logic [3:0] ADDR_GBT_LOSS  = 4'h4;
  localparam logic [3:0] ADDR_MGT_LOSS  = 4'h5;
  localparam logic [3:0] ADDR_L1A       = 4'h6;
  localparam logic [3:0] ADDR_BC0       = 4'h7;
  localparam logic [3:0] ADDR_RESYNC    = 4'h8;
  localparam logic [3:0] ADDR_RATE      = 4'h9;
  localparam logic [3:0] ADDR_CTRL      = 4'hF;
  localparam int ST_MGTS    = 0;
  localparam int ST_GBT     = 1;
  localparam int ST_MMCM    = 2;
  localparam int ST_CORE    = 3;
  localparam int ST_TRIG    = 4;
  localparam int ST_DROPPED = 5;
  localparam int CTRL_CLR_CNT  = 0;
  localparam int CTRL_CLR_DROP = 1;
  typedef enum logic [1:0] {IDLE, CAPTURE, RESPOND} state_t;
endpackage

// File: rtl/status_readback_sat_counter.sv
// sat_counter: event counter that sticks at all-ones; clear wins over a simultaneous increment.
module sat_counter #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 clr,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] count
);
  always_ff @(posedge clock or posedge reset)
    if (reset) count <= '0;
    else count <= clr ? '0 : (inc && count != '1) ? count + 1'b1 : count;
endmodule

// File: rtl/status_readback.sv
// status_readback: slow-control responder reporting lock/ready levels, loss counts, TTC counts and cluster rate.
module status_readback
  import status_readback_pkg::*;
#(
  parameter int CNT_WIDTH   = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mmcm_locked,
  input  logic        core_mmcm_locked,
  input  logic        trigger_mmcm_locked,
  input  logic        mgts_ready,
  input  logic        gbt_link_ready,
  input  logic        ttc_l1a,
  input  logic        ttc_bc0,
  input  logic        ttc_resync,
  input  logic [31:0] cluster_rate,
  input  logic        req_en,
  input  logic        req_we,
  input  logic [3:0]  req_addr,
  input  logic [31:0] req_data,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_err
);
  logic [SYNC_STAGES-1:0][4:0] sync_q;
  logic [4:0] cur, prev, loss, async_in;
  logic [7:0] inc, clr;
  logic [CNT_WIDTH-1:0] cnt [8];
  state_t state;
  logic r_we, dropped, capture, ctrl_wr, clr_cnt, clr_drop, err_next, unused;
  logic [3:0] r_addr;
  logic [1:0] r_ctrl;
  logic [2:0] cnt_sel;
  logic [31:0] rsp_data_next;
  assign async_in = {trigger_mmcm_locked, core_mmcm_locked, mmcm_locked, gbt_link_ready, mgts_ready};
  assign unused = ^req_data[31:2];
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      sync_q <= '0;
      prev <= '0;
    end else begin
      sync_q[0] <= async_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev <= cur;
    end
  assign cur  = sync_q[SYNC_STAGES-1];
  assign loss = prev & ~cur;
  // counter slots are address-1: mmcm, core, trig, gbt, mgts, l1a, bc0, resync
  assign inc = {ttc_resync, ttc_bc0, ttc_l1a, loss[ST_MGTS], loss[ST_GBT], loss[ST_TRIG], loss[ST_CORE], loss[ST_MMCM]};
  assign clr = {clr_cnt, {2{clr_cnt | ttc_resync}}, {5{clr_cnt}}};
  for (genvar g = 0; g < 8; g++) begin : g_cnt
    sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt (
      .clock(clock), .reset(reset), .clr(clr[g]), .inc(inc[g]), .count(cnt[g])
    );
  end
  assign capture  = state == CAPTURE;
  assign ctrl_wr  = capture && r_we && r_addr == ADDR_CTRL;
  assign clr_cnt  = ctrl_wr && r_ctrl[CTRL_CLR_CNT];
  assign clr_drop = ctrl_wr && r_ctrl[CTRL_CLR_DROP];
  assign err_next = r_we ? r_addr != ADDR_CTRL : (r_addr > ADDR_RATE && r_addr != ADDR_CTRL);
  assign cnt_sel  = 3'(r_addr - 4'd1);
  assign rsp_data_next = r_we ? '0 :
                         r_addr == ADDR_STATUS ? 32'({dropped, cur}) :
                         r_addr == ADDR_RATE ? cluster_rate :
                         r_addr <= ADDR_RESYNC ? 32'(cnt[cnt_sel]) : '0;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= IDLE;
      r_we <= 1'b0;
      r_addr <= '0;
      r_ctrl <= '0;
      dropped <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data <= '0;
      rsp_err <= 1'b0;
    end else begin
      dropped <= (req_en && state != IDLE) ? 1'b1 : clr_drop ? 1'b0 : dropped;
      if (state == IDLE && req_en) begin
        r_we <= req_we;
        r_addr <= req_addr;
        r_ctrl <= req_data[1:0];
      end
      state <= state == IDLE ? (req_en ? CAPTURE : IDLE) : capture ? RESPOND : IDLE;
      rsp_valid <= capture;
      rsp_data <= capture ? rsp_data_next : '0;
      rsp_err <= capture && err_next;
    end
endmodule

// File: tb/tb_status_readback.sv
// tb_status_readback: directed scenario tasks with hand-computed expectations for status_readback (CNT_WIDTH=4).
module tb_status_readback;
  logic clock = 1'b0, reset = 1'b1;
  logic mmcm_locked = 1'b1, core_mmcm_locked = 1'b1, trigger_mmcm_locked = 1'b1;
  logic mgts_ready = 1'b1, gbt_link_ready = 1'b1;
  logic ttc_l1a = 1'b0, ttc_bc0 = 1'b0, ttc_resync = 1'b0;
  logic [31:0] cluster_rate = '0;
  logic req_en = 1'b0, req_we = 1'b0;
  logic [3:0] req_addr = '0;
  logic [31:0] req_data = '0;
  logic rsp_valid, rsp_err;
  logic [31:0] rsp_data;
  int n_checks = 0, n_fail = 0;
  logic v1, v2, v3, e;
  logic [31:0] d;

  status_readback #(.CNT_WIDTH(4), .SYNC_STAGES(2)) dut (
    .clock(clock), .reset(reset),
    .mmcm_locked(mmcm_locked), .core_mmcm_locked(core_mmcm_locked),
    .trigger_mmcm_locked(trigger_mmcm_locked), .mgts_ready(mgts_ready),
    .gbt_link_ready(gbt_link_ready), .ttc_l1a(ttc_l1a), .ttc_bc0(ttc_bc0),
    .ttc_resync(ttc_resync), .cluster_rate(cluster_rate), .req_en(req_en),
    .req_we(req_we), .req_addr(req_addr), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  always #5 clock = ~clock;

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Issues one request in the current cycle N and samples rsp_valid at N+1, N+2, N+3.
  task automatic do_req(input logic we, input logic [3:0] addr, input logic [31:0] data,
                        output logic o1, output logic o2, output logic o3,
                        output logic [31:0] od, output logic oe);
    req_en = 1'b1; req_we = we; req_addr = addr; req_data = data;
    step(1);
    req_en = 1'b0;
    o1 = rsp_valid;
    step(1);
    o2 = rsp_valid; od = rsp_data; oe = rsp_err;
    step(1);
    o3 = rsp_valid;
  endtask

  task automatic test_reset;
    step(2);
    n_checks++;
    if ({rsp_valid, rsp_err, rsp_data} !== 34'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%b e=%b d=%h, want all 0", rsp_valid, rsp_err, rsp_data);
    end
    reset = 1'b0;
    step(5);
    do_req(1'b0, 4'h0, '0, v1, v2, v3, d, e);
    n_checks++;
    if ({v1, v2, v3, e, d} !== {3'b010, 1'b0, 32'h0000_001F}) begin
      n_fail++;
      $display("FAIL reset_status: got v=%b%b%b e=%b d=%h, want v=010 e=0 d=0000001f", v1, v2, v3, e, d);
    end
    do_req(1'b0, 4'h1, '0, v1, v2, v3, d, e);
    n_checks++;
    if ({v2, e, d} !== {1'b1, 1'b0, 32'h0}) begin
      n_fail++;
      $display("FAIL reset_no_false_loss: got v=%b e=%b d=%h, want v=1 e=0 d=0", v2, e, d);
    end
  endtask

  task automatic test_loss;
    core_mmcm_locked = 1'b0;
    step(3);
    do_req(1'b0, 4'h0, '0, v1, v2, v3, d, e);
    n_checks++;
    if ({v2, e, d} !== {1'b1, 1'b0, 32'h0000_0017}) begin
      n_fail++;
      $display("FAIL loss_status_low: got v=%b e=%b d=%h, want v=1 e=0 d=00000017", v2, e, d);
    end
    step(4);
    core_mmcm_locked = 1'b1;
    step(5);
    core_mmcm_locked = 1'b0;
    step(10);
    core_mmcm_locked = 1'b1;
    step(5);
    do_req(1'b0, 4'h2, '0, v1, v2, v3, d, e);
    n_checks++;
    if ({v2, e, d} !== {1'b1, 1'b0, 32'd2}) begin
      n_fail++;
      $display("FAIL loss_core_count: got v=%b e=%b d=%h, want v=1 e=0 d=2", v2, e, d);
    end
    do_req(1'b0, 4'h1, '0, v1, v2, v3, d, e);
    n_checks++;
    if (d !== 32'd0) begin
      n_fail++;
      $display("FAIL loss_mmcm_count: got %h, want 0", d);
    end
    do_req(1'b0, 4'h3, '0, v1, v2, v3, d, e);
    n_checks++;
    if (d !== 32'd0) begin
      n_fail++;
      $display("FAIL loss_trig_count: got %h, want 0", d);
    end
    do_req(1'b0, 4'h0, '0, v1, v2, v3, d, e);
    n_checks++;
    if (d !== 32'h0000_001F) begin
      n_fail++;
      $display("FAIL loss_status_high: got %h, want 0000001f", d);
    end
  endtask

  task automatic test_saturation;
    ttc_l1a = 1'b1;
    step(20);
    ttc_l1a = 1'b0;
    step(1);
    do_req(1'b0, 4'h6, '0, v1, v2, v3, d, e);
    n_checks++;
    if ({v2, e, d} !== {1'b1, 1'b0, 32'h0000_000F}) begin
      n_fail++;
      $display("FAIL sat_l1a: got v=%b e=%b d=%h, want v=1 e=0 d=0000000f", v2, e, d);
    end
  endtask

  task automatic test_resync;
    repeat (3) begin
      ttc_bc0 = 1'b1; step(1); ttc_bc0 = 1'b0; step(1);
    end
    do_req(1'b0, 4'h7, '0, v1, v2, v3, d, e);
    n_checks++;
    if (d !== 32'd3) begin
      n_fail++;
      $display("FAIL resync_bc0_before: got %h, want 3", d);
    end
    ttc_bc0 = 1'b1; ttc_resync = 1'b1;
    step(1);
    ttc_bc0 = 1'b0; ttc_resync = 1'b0;
    step(1);
    do_req(1'b0, 4'h7, '0, v1, v2, v3, d, e);
    n_checks++;
    if (d !== 32'd0) begin
      n_fail++;
      $display("FAIL resync_bc0_cleared: got %h, want 0", d);
    end
    do_req(1'b0, 4'h8, '0, v1, v2, v3, d, e);
    n_checks++;
    if (d !== 32'd1) begin
      n_fail++;
      $display("FAIL resync_count: got %h, want 1", d);
    end
    do_req(1'b0, 4'h6, '0, v1, v2, v3, d, e);
    n_checks++;
    if (d !== 32'd0) begin
      n_fail++;
      $display("FAIL resync_l1a_cleared: got %h, want 0", d);
    end
    do_req(1'b0, 4'h2, '0, v1, v2, v3, d, e);
    n_checks++;
    if (d !== 32'd2) begin
      n_fail++;
      $display("FAIL resync_keeps_loss: got %h, want 2", d);
    end
  endtask

  task automatic test_ctrl_clear;
    logic [3:0] addrs [4];
    addrs = '{4'h2, 4'h6, 4'h7, 4'h8};
    ttc_l1a = 1'b1; step(1); ttc_l1a = 1'b0; step(1);
    do_req(1'b1, 4'hF, 32'h1, v1, v2, v3, d, e);
    n_checks++;
    if ({v1, v2, v3, e, d} !== {3'b010, 1'b0, 32'h0}) begin
      n_fail++;
      $display("FAIL ctrl_write_rsp: got v=%b%b%b e=%b d=%h, want v=010 e=0 d=0", v1, v2, v3, e, d);
    end
    foreach (addrs[i]) begin
      do_req(1'b0, addrs[i], '0, v1, v2, v3, d, e);
      n_checks++;
      if ({e, d} !== 33'd0) begin
        n_fail++;
        $display("FAIL ctrl_cleared_%0h: got e=%b d=%h, want e=0 d=0", addrs[i], e, d);
      end
    end
  endtask

  task automatic test_back_to_back;
    int n_rsp = 0;
    logic [31:0] first_d = '0;
    req_en = 1'b1; req_we = 1'b0; req_addr = 4'h0;
    step(2);
    req_en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (rsp_valid) begin
        n_rsp++;
        first_d = rsp_data;
      end
      step(1);
    end
    n_checks++;
    if (n_rsp !== 1) begin
      n_fail++;
      $display("FAIL b2b_one_response: got %0d responses, want 1", n_rsp);
    end
    n_checks++;
    if (first_d !== 32'h0000_001F) begin
      n_fail++;
      $display("FAIL b2b_first_data: got %h, want 0000001f", first_d);
    end
    do_req(1'b0, 4'h0, '0, v1, v2, v3, d, e);
    n_checks++;
    if (d !== 32'h0000_003F) begin
      n_fail++;
      $display("FAIL b2b_dropped_set: got %h, want 0000003f", d);
    end
    do_req(1'b0, 4'h0, '0, v1, v2, v3, d, e);
    n_checks++;
    if (d !== 32'h0000_003F) begin
      n_fail++;
      $display("FAIL b2b_dropped_sticky: got %h, want 0000003f", d);
    end
    do_req(1'b1, 4'hF, 32'h2, v1, v2, v3, d, e);
    n_checks++;
    if ({v2, e} !== 2'b10) begin
      n_fail++;
      $display("FAIL b2b_clear_rsp: got v=%b e=%b, want v=1 e=0", v2, e);
    end
    do_req(1'b0, 4'h0, '0, v1, v2, v3, d, e);
    n_checks++;
    if ({v2, d} !== {1'b1, 32'h0000_001F}) begin
      n_fail++;
      $display("FAIL b2b_dropped_cleared: got v=%b d=%h, want v=1 d=0000001f", v2, d);
    end
  endtask

  task automatic test_errors;
    logic [3:0] bad [3];
    bad = '{4'hA, 4'hB, 4'hE};
    trigger_mmcm_locked = 1'b0; step(5); trigger_mmcm_locked = 1'b1; step(5);
    foreach (bad[i]) begin
      do_req(1'b0, bad[i], '0, v1, v2, v3, d, e);
      n_checks++;
      if ({v2, e, d} !== {1'b1, 1'b1, 32'h0}) begin
        n_fail++;
        $display("FAIL err_read_%0h: got v=%b e=%b d=%h, want v=1 e=1 d=0", bad[i], v2, e, d);
      end
    end
    do_req(1'b1, 4'h3, 32'h55, v1, v2, v3, d, e);
    n_checks++;
    if ({v2, e, d} !== {1'b1, 1'b1, 32'h0}) begin
      n_fail++;
      $display("FAIL err_write_3: got v=%b e=%b d=%h, want v=1 e=1 d=0", v2, e, d);
    end
    do_req(1'b0, 4'h3, '0, v1, v2, v3, d, e);
    n_checks++;
    if ({e, d} !== {1'b0, 32'd1}) begin
      n_fail++;
      $display("FAIL err_trig_unchanged: got e=%b d=%h, want e=0 d=1", e, d);
    end
    do_req(1'b0, 4'hF, '0, v1, v2, v3, d, e);
    n_checks++;
    if ({v2, e, d} !== {1'b1, 1'b0, 32'h0}) begin
      n_fail++;
      $display("FAIL err_read_ctrl: got v=%b e=%b d=%h, want v=1 e=0 d=0", v2, e, d);
    end
    cluster_rate = 32'hDEAD_BEEF;
    do_req(1'b0, 4'h9, '0, v1, v2, v3, d, e);
    n_checks++;
    if ({e, d} !== {1'b0, 32'hDEAD_BEEF}) begin
      n_fail++;
      $display("FAIL rate_read: got e=%b d=%h, want e=0 d=deadbeef", e, d);
    end
  endtask

  task automatic test_async_reset;
    int n_rsp = 0;
    ttc_resync = 1'b1; step(1); ttc_resync = 1'b0; step(1);
    do_req(1'b0, 4'h8, '0, v1, v2, v3, d, e);
    n_checks++;
    if (d !== 32'd1) begin
      n_fail++;
      $display("FAIL areset_pre_count: got %h, want 1", d);
    end
    req_en = 1'b1; req_we = 1'b0; req_addr = 4'h8;
    step(1);
    req_en = 1'b0;
    #2 reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1);
      if (i == 1) reset = 1'b0;
      n_rsp += int'(rsp_valid);
    end
    n_checks++;
    if (n_rsp !== 0) begin
      n_fail++;
      $display("FAIL areset_no_response: got %0d responses, want 0", n_rsp);
    end
    step(4);
    do_req(1'b0, 4'h8, '0, v1, v2, v3, d, e);
    n_checks++;
    if ({v2, d} !== {1'b1, 32'd0}) begin
      n_fail++;
      $display("FAIL areset_count_zero: got v=%b d=%h, want v=1 d=0", v2, d);
    end
    do_req(1'b0, 4'h0, '0, v1, v2, v3, d, e);
    n_checks++;
    if (d !== 32'h0000_001F) begin
      n_fail++;
      $display("FAIL areset_status: got %h, want 0000001f", d);
    end
  endtask

  initial begin
    #1;
    test_reset;
    test_loss;
    test_saturation;
    test_resync;
    test_ctrl_clear;
    test_back_to_back;
    test_errors;
    test_async_reset;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/status_readback.md
Name: status_readback

Overview:
- Slow-control read/write responder for the board-health signals that drive the front-panel LEDs: clock-lock, link-ready and TTC events, plus the cluster rate.
- Reports current levels, sticky loss counts and TTC event counts as 32-bit registers over a simple request/response bus.
- Sits beside the LED controller on the same status nets.
- Serviced by the GBT slow-control request path.

Parameters:
- CNT_WIDTH, 16, width of every event/loss counter; counters saturate at all-ones and are zero-extended to 32 bits on readout.
- SYNC_STAGES, 2, synchronizer depth for asynchronous lock/ready inputs.

Ports:
- clock  in  1  40 MHz fabric clock.
- reset  in  1  asynchronous, active-high reset.
- mmcm_locked, core_mmcm_locked, trigger_mmcm_locked  in  1 each  asynchronous lock levels.
- mgts_ready, gbt_link_ready  in  1 each  asynchronous ready levels.
- ttc_l1a, ttc_bc0, ttc_resync  in  1 each  single-cycle pulses, synchronous to clock.
- cluster_rate  in  32  rate value, synchronous to clock.
- req_en  in  1  request strobe, one cycle.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  4  register address.
- req_data  in  32  write data.
- rsp_valid  out  1  one-cycle response strobe.
- rsp_data  out  32  read data; 0 on writes and errors.
- rsp_err  out  1  bad address or illegal write; valid with rsp_valid.

Behaviour:
- Reset state: all outputs 0, all counters 0, all synchronizer and edge registers 0, FSM in IDLE.
- Async inputs pass through SYNC_STAGES flops, then a previous-value register.
  - Loss event = prev & ~cur.
  - Counter increments 3 cycles after the raw falling edge.
  - Rising edges are not counted.
  - No false event at reset release, because prev resets to 0.
- TTC pulses count on the cycle after the pulse.
- All counters saturate at 2^CNT_WIDTH-1 and never wrap.
- Register map (read unless noted):
  - 0x0 STATUS: [0] mgts_ready, [1] gbt_link_ready, [2] mmcm_locked, [3] core_mmcm_locked, [4] trigger_mmcm_locked (all synchronized levels); [5] req_dropped, sticky; [31:6] 0.
  - 0x1 mmcm_locked loss count.
  - 0x2 core_mmcm_locked loss count.
  - 0x3 trigger_mmcm_locked loss count.
  - 0x4 gbt_link_ready loss count.
  - 0x5 mgts_ready loss count.
  - 0x6 L1A count.
  - 0x7 BC0 count.
  - 0x8 resync count.
  - 0x9 cluster_rate, sampled at capture.
  - 0xF CTRL, write-only:
    - bit0 = clear all counters.
    - bit1 = clear req_dropped.
    - A read of 0xF returns 0 with rsp_err=0.
  - 0xA–0xE: undefined; any access sets rsp_err=1.
  - A write to any address other than 0xF sets rsp_err=1 and has no side effect.
- ttc_resync clears 0x6 and 0x7 on the following cycle.
  - Resync does not clear 0x8 or the loss counters.
  - 0x8 increments on the same resync.
- Clear priority: CTRL clear or resync beats a simultaneous increment; the counter reads 0 afterwards.
- FSM states:
  - IDLE: on req_en, latch req_* and go to CAPTURE.
  - CAPTURE: mux the addressed register into rsp_data_next, decode the error, perform the CTRL write action, go to RESPOND.
  - RESPOND: assert rsp_valid with rsp_data/rsp_err for exactly one cycle, go to IDLE.
- Latency and throughput:
  - Request at cycle N gives rsp_valid at cycle N+2.
  - Back-to-back requests are accepted every 3 cycles.
- req_en while not in IDLE is dropped (no response) and sets req_dropped.
- Read data is the counter value at the CAPTURE cycle.
- Async reset mid-transaction: returns to IDLE, no response is issued, counters are zeroed.

Decomposition:
- Package status_readback_pkg holds:
  - Address constants ADDR_STATUS … ADDR_CTRL.
  - STATUS bit indices.
  - CTRL bit indices.
  - FSM state encoding (IDLE, CAPTURE, RESPOND).
- One sub-module, sat_counter (CNT_WIDTH; ports clock, reset, clr, inc, count), instantiated 8 times.

Test Plan:
- Release reset with all lock inputs high, wait 5 cycles, read 0x0 -> rsp_valid at N+2, rsp_data=0x0000001F, rsp_err=0.
- Drop core_mmcm_locked for 10 cycles, twice -> read 0x2 = 2; 0x1 and 0x3 = 0; STATUS[3] follows the level.
- With CNT_WIDTH=4, issue 20 ttc_l1a pulses -> 0x6 = 0x0000000F.
- Pulse ttc_resync in the same cycle as ttc_bc0 -> 0x7 = 0, 0x8 = 1.
- Write 0x1 to 0xF -> rsp_err=0, and every counter then reads 0.
- Req at N and again at N+1 -> exactly one response; STATUS[5]=1 until 0x2 is written to 0xF.
- Read 0xB -> rsp_err=1, rsp_data=0.
- Write 0x3 -> rsp_err=1, and the 0x3 count is unchanged.
